// File: rtl/clint_pkg.sv
// Shared encodings for the core-local interrupt sequencer: instruction
// patterns, CSR addresses, cause codes, FSM states and mstatus helpers.
package clint_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_INT_BASE = 32'h8000_0010;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_MEPC    = 3'd1;
  localparam logic [2:0] S_W_MSTATUS = 3'd2;
  localparam logic [2:0] S_W_MCAUSE  = 3'd3;
  localparam logic [2:0] S_W_MRET    = 3'd4;
  localparam logic [2:0] S_ASSERT    = 3'd5;

  // Trap entry: stash MIE into MPIE and mask further interrupts.
  function automatic logic [31:0] mstatus_enter(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: holds the pipeline, writes
// mepc/mstatus/mcause, then redirects. Optional CLINT_EBREAK_EN makes ebreak trap.
module clint
  import clint_pkg::*;
#(
  parameter int INT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  input  logic             global_int_en_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [11:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

`ifdef CLINT_EBREAK_EN
  localparam logic EBREAK_EN = 1'b1;
`else
  localparam logic EBREAK_EN = 1'b0;
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        assert_q, assert_d;
  logic [31:0] addr_q, addr_d;

  logic        is_ecall;
  logic        is_ebreak;
  logic        sync_det;
  logic        int_det;
  logic        mret_det;
  logic        idle;
  logic [31:0] int_idx;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = EBREAK_EN && (inst_i == INST_EBREAK);
  assign sync_det  = (is_ecall || is_ebreak) && !jump_flag_i;
  assign int_det   = (|int_flag_i) && csr_mstatus_i[3] && global_int_en_i && !div_started_i;
  assign mret_det  = (inst_i == INST_MRET) && !jump_flag_i;
  assign idle      = (state_q == S_IDLE);

  // Descending scan so the lowest set line wins.
  always_comb begin
    int_idx = 32'd0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (int_flag_i[i]) int_idx = 32'(i);
    end
  end

  assign hold_flag_o = !rst && (!idle || sync_det || int_det || mret_det);

  // Output registers carry the write for the state being entered, so each
  // state's cycle is exactly the cycle its CSR write is visible.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    we_d     = 1'b0;
    waddr_d  = 12'h000;
    data_d   = 32'h0;
    assert_d = 1'b0;
    addr_d   = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (sync_det) begin
          state_d = S_W_MEPC;
          cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          we_d    = 1'b1;
          waddr_d = CSR_MEPC;
          data_d  = inst_addr_i;
        end else if (int_det) begin
          state_d = S_W_MEPC;
          cause_d = CAUSE_INT_BASE + int_idx;
          we_d    = 1'b1;
          waddr_d = CSR_MEPC;
          data_d  = jump_flag_i ? jump_addr_i : inst_addr_i;
        end else if (mret_det) begin
          state_d = S_W_MRET;
          we_d    = 1'b1;
          waddr_d = CSR_MSTATUS;
          data_d  = mstatus_mret(csr_mstatus_i);
        end
      end
      S_W_MEPC: begin
        state_d = S_W_MSTATUS;
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mstatus_enter(csr_mstatus_i);
      end
      S_W_MSTATUS: begin
        state_d = S_W_MCAUSE;
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      S_W_MCAUSE: begin
        state_d  = S_ASSERT;
        assert_d = 1'b1;
        addr_d   = csr_mtvec_i;
      end
      S_W_MRET: begin
        state_d  = S_ASSERT;
        assert_d = 1'b1;
        addr_d   = csr_mepc_i;
      end
      S_ASSERT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cause_q  <= 32'h0;
      we_q     <= 1'b0;
      waddr_q  <= 12'h000;
      data_q   <= 32'h0;
      assert_q <= 1'b0;
      addr_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = assert_q;
  assign int_addr_o   = addr_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: directed scenarios then random traffic, checked against a
// transaction-level model that emits the expected per-cycle write/redirect list.
module tb_clint;

  typedef struct packed {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] data;
    logic        as;
    logic [31:0] addr;
  } exp_t;

`ifdef CLINT_EBREAK_EN
  localparam bit EBREAK_EN = 1'b1;
`else
  localparam bit EBREAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        div_started;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mcause;
  logic        gie;
  logic        hold_flag;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] data;
  logic        int_assert;
  logic [31:0] int_addr;

  int   checks_cnt = 0;
  int   fail_cnt   = 0;
  bit   skip_chk   = 1'b0;
  bit   chk_all    = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  clint #(.INT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .int_flag_i     (int_flag),
    .inst_i         (inst),
    .inst_addr_i    (inst_addr),
    .jump_flag_i    (jump_flag),
    .jump_addr_i    (jump_addr),
    .div_started_i  (div_started),
    .csr_mtvec_i    (csr_mtvec),
    .csr_mepc_i     (csr_mepc),
    .csr_mstatus_i  (csr_mstatus),
    .global_int_en_i(gie),
    .hold_flag_o    (hold_flag),
    .we_o           (we),
    .waddr_o        (waddr),
    .data_o         (data),
    .int_assert_o   (int_assert),
    .int_addr_o     (int_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic step();
    exp_t        cur;
    exp_t        e;
    bit          busy;
    bit          m_sync, m_int, m_mret, m_ecall;
    logic [31:0] epc, cause, mst;
    int          n;
    #1;
    busy    = (exp_q.size() != 0);
    cur     = busy ? exp_q[0] : '0;
    m_ecall = (inst == 32'h0000_0073);
    m_sync  = (m_ecall || (EBREAK_EN && inst == 32'h0010_0073)) && !jump_flag;
    m_int   = (int_flag != 8'h0) && csr_mstatus[3] && gie && !div_started;
    m_mret  = (inst == 32'h3020_0073) && !jump_flag;
    if (!skip_chk) begin
      check("hold", {31'b0, hold_flag}, {31'b0, !rst && (busy || m_sync || m_int || m_mret)});
      check("we", {31'b0, we}, {31'b0, cur.we});
      check("assert", {31'b0, int_assert}, {31'b0, cur.as});
      if (cur.we || chk_all) begin
        check("waddr", {20'b0, waddr}, {20'b0, cur.waddr});
        check("data", data, cur.data);
      end
      if (cur.as || chk_all) check("int_addr", int_addr, cur.addr);
    end
    @(posedge clk);
    #1;
    chk_all = rst;
    if (rst) begin
      exp_q.delete();
    end else if (busy) begin
      e = exp_q.pop_front();
      if (e.we) begin
        case (e.waddr)
          12'h300: csr_mstatus = e.data;
          12'h341: csr_mepc    = e.data;
          12'h342: csr_mcause  = e.data;
          default: ;
        endcase
      end
    end else if (m_sync || m_int) begin
      n = -1;
      for (int i = 0; i < 8; i++) if (int_flag[i] && n < 0) n = i;
      if (m_sync) begin
        epc   = inst_addr;
        cause = m_ecall ? 32'd11 : 32'd3;
      end else begin
        epc   = jump_flag ? jump_addr : inst_addr;
        cause = 32'h8000_0010 + n;
      end
      mst = csr_mstatus;
      mst[7] = csr_mstatus[3];
      mst[3] = 1'b0;
      exp_q.push_back('{1'b1, 12'h341, epc, 1'b0, 32'h0});
      exp_q.push_back('{1'b1, 12'h300, mst, 1'b0, 32'h0});
      exp_q.push_back('{1'b1, 12'h342, cause, 1'b0, 32'h0});
      exp_q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, csr_mtvec});
      $display("txn entry %s epc=%h cause=%h mtvec=%h", m_sync ? "sync" : "irq", epc, cause, csr_mtvec);
    end else if (m_mret) begin
      mst = csr_mstatus;
      mst[3] = csr_mstatus[7];
      mst[7] = 1'b1;
      exp_q.push_back('{1'b1, 12'h300, mst, 1'b0, 32'h0});
      exp_q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, csr_mepc});
      $display("txn mret mstatus=%h mepc=%h", mst, csr_mepc);
    end
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic quiet();
    rst = 1'b0; inst = 32'h0000_0013; jump_flag = 1'b0; int_flag = 8'h0;
    div_started = 1'b0; gie = 1'b1;
  endtask

  initial begin
    quiet();
    rst = 1'b1; inst_addr = 32'h0; jump_addr = 32'h0;
    csr_mtvec = 32'h0; csr_mepc = 32'h0; csr_mstatus = 32'h0; csr_mcause = 32'h0;
    @(negedge clk);
    skip_chk = 1'b1; step(); skip_chk = 1'b0;
    step();
    rst = 1'b0;
    chk_all = 1'b1; step();

    // ecall entry
    csr_mtvec = 32'h200; csr_mstatus = 32'h8;
    inst = 32'h0000_0073; inst_addr = 32'h100; step();
    inst = 32'h13; steps(5);
    // interrupt during EX redirect, dropped mid-sequence
    csr_mstatus = 32'h8; int_flag = 8'b0000_0100; jump_flag = 1'b1; jump_addr = 32'h40; step();
    int_flag = 8'h0; jump_flag = 1'b0; steps(5);
    // mret
    csr_mepc = 32'h104; csr_mstatus = 32'h80; inst = 32'h3020_0073; step();
    inst = 32'h13; steps(3);
    // blocked by MIE, then by divide
    csr_mstatus = 32'h0; int_flag = 8'h01; steps(3);
    csr_mstatus = 32'h8; steps(7);
    csr_mstatus = 32'h8; div_started = 1'b1; steps(2);
    div_started = 1'b0; steps(6);
    int_flag = 8'h0;
    // squashed ecall, then reset in W_MSTATUS
    inst = 32'h73; jump_flag = 1'b1; steps(2);
    jump_flag = 1'b0; step();
    inst = 32'h13; step();
    rst = 1'b1; step();
    rst = 1'b0; steps(4);
    // ebreak
    csr_mstatus = 32'h8; inst = 32'h0010_0073; inst_addr = 32'h300; step();
    inst = 32'h13; steps(5);
    // ecall and interrupt together
    csr_mstatus = 32'h8; int_flag = 8'h01; inst = 32'h73; step();
    inst = 32'h13; steps(6);
    quiet();

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0: inst = 32'h0000_0073;
        1: inst = 32'h0010_0073;
        2: inst = 32'h3020_0073;
        3: inst = 32'h0000_0013;
        default: inst = $urandom;
      endcase
      inst_addr   = $urandom & 32'hFFFF_FFFC;
      jump_addr   = $urandom & 32'hFFFF_FFFC;
      jump_flag   = ($urandom_range(0, 3) == 0);
      int_flag    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
      div_started = ($urandom_range(0, 3) == 0);
      gie         = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 60) == 0);
      if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        csr_mstatus = $urandom;
        csr_mtvec   = $urandom & 32'hFFFF_FFFC;
        csr_mepc    = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end
    quiet();
    steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt/exception sequencer that is the requesting side of the pipeline-control hold interface. It detects `ecall`/`ebreak`/`mret` in ID and qualified external interrupts. It raises a hold request to the pipeline controller, performs the machine-mode CSR writes (`mepc`, `mstatus`, `mcause`) in sequence over the CSR write port, and then issues a one-cycle redirect to `mtvec` or `mepc`. It sits between ID/EX and the CSR register file, and its hold output feeds the controller's `clint_hold_flag_i`.

## Interface
- `INT_W`, default 8: number of external interrupt lines.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `int_flag_i`  in  INT_W  level interrupt requests, bit 0 highest priority
- `inst_i`  in  32  instruction in ID
- `inst_addr_i`  in  32  address of `inst_i`
- `jump_flag_i`  in  1  EX redirect this cycle
- `jump_addr_i`  in  32  EX redirect target
- `div_started_i`  in  1  multi-cycle divide in flight
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i`  in  32 each  current CSR values
- `global_int_en_i`  in  1  CSR-side global interrupt enable
- `hold_flag_o`  out  1  hold request to pipeline control
- `we_o`  out  1  CSR write enable
- `waddr_o`  out  12  CSR write address
- `data_o`  out  32  CSR write data
- `int_assert_o`  out  1  redirect strobe
- `int_addr_o`  out  32  redirect target

## Operation
- States: `IDLE`, `W_MEPC`, `W_MSTATUS`, `W_MCAUSE`, `W_MRET`, `ASSERT`.
- Detection happens in `IDLE` only. Priority is sync exception > async interrupt > `mret`.
- Sync exception:
  - Triggered when `inst_i` is `ecall` (32'h0000_0073) or `ebreak` (32'h0010_0073) and `jump_flag_i` = 0. When `jump_flag_i` = 1 the instruction is squashed and ignored.
  - `mepc` ← `inst_addr_i`.
  - `mcause` ← 11 for `ecall`, 3 for `ebreak`.
- Async interrupt:
  - Triggered when `int_flag_i` != 0, `csr_mstatus_i[3]` (MIE) = 1, `global_int_en_i` = 1 and `div_started_i` = 0. If a divide is in flight, detection is deferred.
  - `mepc` ← `jump_addr_i` if `jump_flag_i`, else `inst_addr_i`.
  - `mcause` ← 32'h8000_0010 + n, where n is the lowest set bit index.
- Entry path: `W_MEPC` → `W_MSTATUS` → `W_MCAUSE` → `ASSERT` → `IDLE`. Cause, return address and source are latched at detection.
- `W_MSTATUS` data: `csr_mstatus_i` with bit 7 (MPIE) ← bit 3, and bit 3 (MIE) ← 0.
- `mret` (32'h3020_0073, `jump_flag_i` = 0): `W_MRET` → `ASSERT`.
- `W_MRET` data: `csr_mstatus_i` with bit 3 ← bit 7, and bit 7 ← 1.
- `ASSERT`: `int_assert_o` = 1 for one cycle. `int_addr_o` = `csr_mtvec_i` on the entry path, `csr_mepc_i` on the `mret` path.
- CSR addresses: `mstatus` 12'h300, `mepc` 12'h341, `mcause` 12'h342.
- `hold_flag_o` is combinational: (state != `IDLE`) | (a detection qualifies in `IDLE` this cycle).

## Timing
- `we_o`, `waddr_o`, `data_o`, `int_assert_o` and `int_addr_o` are registered.
- Reset values: state `IDLE`; all outputs 0, including `hold_flag_o` (no detection during reset).
- Entry path, detection in cycle N:
  - `hold_flag_o` is 1 in N through N+4.
  - Writes occur in N+1 (`mepc`), N+2 (`mstatus`) and N+3 (`mcause`).
  - `int_assert_o` is 1 in N+4.
  - Back in `IDLE` at N+5.
- `mret` path: `mstatus` write in N+1, `int_assert_o` in N+2, `IDLE` at N+3.
- `we_o` is 0 in `IDLE` and `ASSERT`.
- Interrupts arriving mid-sequence are not latched. They are re-evaluated in `IDLE` and must remain asserted; MIE is already 0 by then on the entry path.
- Reset mid-sequence aborts immediately: no further writes and no redirect.
- Simultaneous `ecall` and interrupt: the `ecall` is taken and the interrupt is re-evaluated after return to `IDLE`.

## Configuration
- `CLINT_EBREAK_EN`
  - Defined: `ebreak` is a sync exception with `mcause` = 3.
  - Undefined: `ebreak` is not detected, causes no hold, and passes as a no-op.

## Structure
- Instruction encodings, CSR addresses, state encodings and cause codes go in the shared defines file (`defines.v`).
- No sub-module. The priority encoder for the interrupt index stays inline.

## Test plan
- `ecall` at 0x0000_0100, mtvec = 0x0000_0200, mstatus = 0x8 → `hold_flag_o` high for 5 cycles; writes (0x341, 0x100), then (0x300, 0x80), then (0x342, 11); then `int_assert_o` with 0x200.
- `int_flag_i` = 8'b0000_0100, MIE = 1, `jump_flag_i` = 1, `jump_addr_i` = 0x40 → `mepc` = 0x40, `mcause` = 0x8000_0012.
- `mret` with mepc = 0x104, mstatus = 0x80 → write (0x300, 0x88), then `int_assert_o` with 0x104; `hold_flag_o` high for 3 cycles.
- Interrupt while MIE = 0 or `div_started_i` = 1 → no hold and no write; when the blocker clears, entry starts the same cycle.
- `ecall` with `jump_flag_i` = 1 → ignored. `rst` asserted in `W_MSTATUS` → next cycle all outputs 0, no `mcause` write, no redirect.
- `ebreak` → with `CLINT_EBREAK_EN` defined, `mcause` = 3; without it, `hold_flag_o` stays 0.
